// File: rtl/mod_n_stream_detector.sv
// Multi-channel serial divisibility detector: per-channel running value mod DIVISOR.
// Optional saturating per-channel hit counters are built when MOD_N_HIT_CNT_EN is defined.
module mod_n_stream_detector #(
  parameter int DIVISOR   = 5,
  parameter bit LSB_FIRST = 1'b0,
  parameter int NUM_CH    = 4,
  parameter int REM_W     = $clog2(DIVISOR)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH-1:0]       in_bit,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH*REM_W-1:0] rem,
  output logic [NUM_CH-1:0]       first_1_seen,
  output logic [NUM_CH-1:0]       div,
  output logic [NUM_CH-1:0]       hit
`ifdef MOD_N_HIT_CNT_EN
  ,
  output logic [NUM_CH*8-1:0]     hit_cnt
`endif
);

  localparam logic [REM_W:0] MOD = (REM_W+1)'(DIVISOR);

  // Inputs are always below 2*DIVISOR, so one subtract folds them.
  function automatic logic [REM_W-1:0] fold(
    input logic [REM_W:0] x
  );
    logic [REM_W:0] y;
    y = (x >= MOD) ? x - MOD : x;
    return y[REM_W-1:0];
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [REM_W-1:0] rem_q;
    logic [REM_W-1:0] rem_n;
    logic             seen_q;
    logic             hit_q;
    logic             acc;
    logic             hit_n;

    assign acc   = in_valid[c] & ~clr[c];
    assign hit_n = (rem_n == '0) & (seen_q | in_bit[c]);

    if (LSB_FIRST) begin : g_lsb
      logic [REM_W-1:0] pow_q;

      assign rem_n = fold({1'b0, rem_q} +
                          (in_bit[c] ? {1'b0, pow_q} : '0));

      // Weight of the next bit: 2^k mod DIVISOR, restarting at 1.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          pow_q <= REM_W'(1);
        else if (clr[c])
          pow_q <= REM_W'(1);
        else if (acc)
          pow_q <= fold({pow_q, 1'b0});
      end
    end else begin : g_msb
      assign rem_n = fold({rem_q, 1'b0} +
                          (REM_W+1)'(in_bit[c]));
    end

    // Remainder, leading-one flag and hit pulse per channel.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rem_q  <= '0;
        seen_q <= 1'b0;
        hit_q  <= 1'b0;
      end else if (clr[c]) begin
        rem_q  <= '0;
        seen_q <= 1'b0;
        hit_q  <= 1'b0;
      end else if (acc) begin
        rem_q  <= rem_n;
        seen_q <= seen_q | in_bit[c];
        hit_q  <= hit_n;
      end else begin
        hit_q  <= 1'b0;
      end
    end

    assign rem[c*REM_W +: REM_W] = rem_q;
    assign first_1_seen[c]       = seen_q;
    assign div[c]                = (rem_q == '0) & seen_q;
    assign hit[c]                = hit_q;

`ifdef MOD_N_HIT_CNT_EN
    logic [7:0] cnt_q;

    // Saturating count of hits, bumped on the same edge hit rises.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        cnt_q <= '0;
      else if (clr[c])
        cnt_q <= '0;
      else if (acc && hit_n && cnt_q != 8'hff)
        cnt_q <= cnt_q + 8'd1;
    end

    assign hit_cnt[c*8 +: 8] = cnt_q;
`endif
  end

endmodule
